// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared types and helpers for the countdown timer
// Contents:
//   state_t          - controller state encoding (IDLE, RUN, PAUSED, EXPIRED)
//   prescale_width() - counter width needed for a given prescale ratio (min 1)
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // A prescale of 1 still needs a one-bit counter so the port widths stay legal.
    function automatic int prescale_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control/status bundle between user logic and the countdown timer
// Signals:
//   load, load_value - synchronous load request and value
//   start, pause     - level controls sampled every cycle
//   count            - remaining count (registered)
//   running, expired - registered state decodes
//   done             - one-cycle pulse on entry to EXPIRED
// Modports: master = control side, slave = timer side.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);

    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             expired;
    logic             done;

    modport master (
        output load, load_value, start, pause,
        input  count, running, expired, done
    );

    modport slave (
        input  load, load_value, start, pause,
        output count, running, expired, done
    );

endinterface

// File: rtl/countdown_timer_tick_gen.sv
// rtl/countdown_timer_tick_gen.sv - prescaler producing one decrement tick every PRESCALE enabled cycles
// Ports:
//   clk   in  clock, rising edge
//   reset in  synchronous, active-high
//   en    in  advance the prescaler this cycle
//   clr   in  return the prescaler to zero (dominates en)
//   tick  out combinational, high when en and the prescaler is at its last phase
module tick_gen
    import countdown_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = prescale_width(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // Holding (en low, clr low) preserves the phase across a pause.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // With PRESCALE == 1 the counter is pinned at 0 == LAST, so tick follows en.
    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with start/pause, prescaled ticks and expiry pulse
// Parameters:
//   WIDTH    - count / load value width (>= 2)
//   PRESCALE - clock cycles per decrement while running (>= 1)
// Ports:
//   clk   in  clock, rising edge
//   reset in  synchronous, active-high
//   bus   slave modport of countdown_timer_if (load/load_value/start/pause in,
//         count/running/expired/done out, all outputs registered)
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic               clk,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_count;
    logic             done_q;
    logic             next_done;
    logic             running_q;
    logic             expired_q;

    logic             start_req;
    logic             tick;
    logic             tick_en;
    logic             tick_clr;

    // pause outranks start, so a start only counts when pause is low.
    assign start_req = bus.start && !bus.pause;

    // The prescaler only advances while genuinely counting; load and pause
    // both freeze it so a concurrent tick is discarded.
    assign tick_en  = (state == RUN) && !bus.load && !bus.pause;
    assign tick_clr = bus.load || ((state == IDLE) && start_req);

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        next_state = state;
        next_count = count_q;
        next_done  = 1'b0;

        if (bus.load) begin
            next_state = IDLE;
            next_count = bus.load_value;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_req) begin
                        if (count_q != '0) begin
                            next_state = RUN;
                        end else begin
                            next_state = EXPIRED;
                            next_done  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        next_state = PAUSED;
                    end else if (tick) begin
                        // Expire on the tick that would reach zero; <= 1 also
                        // guards against ever wrapping below zero.
                        if (count_q <= WIDTH'(1)) begin
                            next_count = '0;
                            next_state = EXPIRED;
                            next_done  = 1'b1;
                        end else begin
                            next_count = count_q - 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (start_req) begin
                        next_state = RUN;
                    end
                end
                EXPIRED: begin
                    next_count = '0;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // running/expired are registered from next_state so they line up with
    // the state register rather than lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count_q   <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state     <= next_state;
            count_q   <= next_count;
            done_q    <= next_done;
            running_q <= (next_state == RUN);
            expired_q <= (next_state == EXPIRED);
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer (PRESCALE 4 and 1 side by side)
module tb_countdown_timer;

    localparam int W = 8;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSED  = 2;
    localparam int M_EXPIRED = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(W)) bus4 ();
    countdown_timer_if #(.WIDTH(W)) bus1 ();

    assign bus4.load       = load;
    assign bus4.load_value = load_value;
    assign bus4.start      = start;
    assign bus4.pause      = pause;
    assign bus1.load       = load;
    assign bus1.load_value = load_value;
    assign bus1.start      = start;
    assign bus1.pause      = pause;

    countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Reference model: remaining value plus elapsed running cycles since the
    // last decrement; index 0 models PRESCALE 4, index 1 models PRESCALE 1.
    int m_count [2];
    int m_mode  [2];
    int m_phase [2];
    int m_done  [2];
    int pre     [2] = '{4, 1};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            m_done[d] = 0;
            if (reset) begin
                m_count[d] = 0;
                m_mode[d]  = M_IDLE;
                m_phase[d] = 0;
            end else if (load) begin
                m_count[d] = int'(load_value);
                m_mode[d]  = M_IDLE;
                m_phase[d] = 0;
            end else if (m_mode[d] == M_IDLE) begin
                if (start && !pause) begin
                    if (m_count[d] == 0) begin
                        m_mode[d] = M_EXPIRED;
                        m_done[d] = 1;
                    end else begin
                        m_mode[d]  = M_RUN;
                        m_phase[d] = 0;
                    end
                end
            end else if (m_mode[d] == M_RUN) begin
                if (pause) begin
                    m_mode[d] = M_PAUSED;
                end else begin
                    m_phase[d]++;
                    if (m_phase[d] == pre[d]) begin
                        m_phase[d] = 0;
                        m_count[d]--;
                        if (m_count[d] == 0) begin
                            m_mode[d] = M_EXPIRED;
                            m_done[d] = 1;
                        end
                    end
                end
            end else if (m_mode[d] == M_PAUSED) begin
                if (start && !pause) m_mode[d] = M_RUN;
            end
        end
    endtask

    // One clock: model advances on the edge, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("p4 count",   int'(bus4.count),   m_count[0]);
        chk("p4 running", int'(bus4.running), int'(m_mode[0] == M_RUN));
        chk("p4 expired", int'(bus4.expired), int'(m_mode[0] == M_EXPIRED));
        chk("p4 done",    int'(bus4.done),    m_done[0]);
        chk("p1 count",   int'(bus1.count),   m_count[1]);
        chk("p1 running", int'(bus1.running), int'(m_mode[1] == M_RUN));
        chk("p1 expired", int'(bus1.expired), int'(m_mode[1] == M_EXPIRED));
        chk("p1 done",    int'(bus1.done),    m_done[1]);
    endtask

    task automatic drive(input bit r, input bit ld, input int lv, input bit st, input bit ps);
        reset      = r;
        load       = ld;
        load_value = W'(lv);
        start      = st;
        pause      = ps;
    endtask

    typedef struct {
        bit r;
        bit ld;
        int lv;
        bit st;
        bit ps;
        int e_count;
        bit e_run;
        bit e_exp;
        bit e_done;
    } vec_t;

    vec_t vt[$];
    int   edges;
    int   low_cycles;

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_count[d] = 0;
            m_mode[d]  = M_IDLE;
            m_phase[d] = 0;
            m_done[d]  = 0;
        end

        // Expected values for the PRESCALE=4 instance, one row per clock.
        vt.push_back('{1, 0, 0, 0, 0,  0, 0, 0, 0});   // reset
        vt.push_back('{0, 1, 3, 0, 0,  3, 0, 0, 0});   // load 3
        vt.push_back('{0, 0, 0, 1, 0,  3, 1, 0, 0});   // start at edge k
        vt.push_back('{0, 0, 0, 0, 0,  3, 1, 0, 0});
        vt.push_back('{0, 0, 0, 0, 0,  3, 1, 0, 0});
        vt.push_back('{0, 0, 0, 0, 0,  3, 1, 0, 0});
        vt.push_back('{0, 0, 0, 0, 0,  2, 1, 0, 0});   // k+4
        vt.push_back('{0, 0, 0, 0, 0,  2, 1, 0, 0});
        vt.push_back('{0, 0, 0, 0, 0,  2, 1, 0, 0});
        vt.push_back('{0, 0, 0, 0, 0,  2, 1, 0, 0});
        vt.push_back('{0, 0, 0, 0, 0,  1, 1, 0, 0});   // k+8
        vt.push_back('{0, 0, 0, 0, 0,  1, 1, 0, 0});
        vt.push_back('{0, 0, 0, 0, 0,  1, 1, 0, 0});
        vt.push_back('{0, 0, 0, 0, 0,  1, 1, 0, 0});
        vt.push_back('{0, 0, 0, 0, 0,  0, 0, 1, 1});   // k+12: expiry, done pulse
        vt.push_back('{0, 0, 0, 0, 0,  0, 0, 1, 0});   // done drops
        vt.push_back('{0, 0, 0, 1, 0,  0, 0, 1, 0});   // start ignored in EXPIRED
        vt.push_back('{0, 1, 9, 1, 1,  9, 0, 0, 0});   // load outranks start/pause
        vt.push_back('{0, 0, 0, 1, 1,  9, 0, 0, 0});   // start && pause in IDLE
        vt.push_back('{0, 0, 0, 0, 1,  9, 0, 0, 0});   // pause alone in IDLE
        vt.push_back('{0, 0, 0, 1, 0,  9, 1, 0, 0});   // start

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].r, vt[i].ld, vt[i].lv, vt[i].st, vt[i].ps);
            cycle();
            chk($sformatf("vec%0d count", i),   int'(bus4.count),   vt[i].e_count);
            chk($sformatf("vec%0d running", i), int'(bus4.running), int'(vt[i].e_run));
            chk($sformatf("vec%0d expired", i), int'(bus4.expired), int'(vt[i].e_exp));
            chk($sformatf("vec%0d done", i),    int'(bus4.done),    int'(vt[i].e_done));
        end

        // Load lands on the same edge as the PRESCALE=4 tick: no decrement.
        drive(0, 0, 0, 0, 0);
        repeat (3) cycle();
        chk("pre-tick count", int'(bus4.count), 9);
        drive(0, 1, 9, 0, 0);
        cycle();
        chk("load on tick count",   int'(bus4.count),   9);
        chk("load on tick running", int'(bus4.running), 0);

        // Reset held two cycles mid-run with count 5: no done pulse.
        drive(0, 1, 5, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();
        chk("mid-run count", int'(bus4.count), 5);
        drive(1, 0, 0, 0, 0);
        repeat (2) begin
            cycle();
            chk("reset count",   int'(bus4.count),   0);
            chk("reset running", int'(bus4.running), 0);
            chk("reset done",    int'(bus4.done) | int'(bus1.done), 0);
        end

        // Pause/resume on PRESCALE=1: six cycles with pause held plus the
        // resume edge give seven non-counting cycles, so expiry moves from
        // k+10 to k+17.
        drive(0, 1, 10, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 0);
        repeat (4) cycle();
        chk("pre-pause count", int'(bus1.count), 6);
        drive(0, 0, 0, 1, 1);
        low_cycles = 0;
        repeat (6) begin
            cycle();
            chk("paused count", int'(bus1.count), 6);
            if (!bus1.running) low_cycles++;
        end
        chk("paused cycles", low_cycles, 6);
        drive(0, 0, 0, 1, 0);
        cycle();
        chk("resume running", int'(bus1.running), 1);
        chk("resume count",   int'(bus1.count),   6);
        drive(0, 0, 0, 0, 0);
        edges = 11;
        for (int i = 0; i < 40 && !bus1.done; i++) begin
            cycle();
            edges++;
        end
        chk("pause expiry edge", edges, 17);

        // Zero load: start goes straight to EXPIRED with a single pulse.
        drive(0, 1, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 0);
        cycle();
        chk("zero done",    int'(bus1.done) & int'(bus4.done), 1);
        chk("zero expired", int'(bus1.expired), 1);
        chk("zero count",   int'(bus1.count),   0);
        repeat (2) begin
            cycle();
            chk("zero no second pulse", int'(bus1.done) | int'(bus4.done), 0);
        end

        // Max value on PRESCALE=1: done exactly 255 edges after RUN entry.
        drive(0, 1, 255, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 0);
        edges = 0;
        for (int i = 0; i < 300 && !bus1.done; i++) begin
            cycle();
            edges++;
            if (bus1.count == 8'd255) chk("max no wrap", int'(bus1.count), 254 - i);
        end
        chk("max expiry edge", edges, 255);
        repeat (3) cycle();
        chk("max held zero", int'(bus1.count), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 127) == 0),
                  ($urandom_range(0, 31) == 0),
                  int'($urandom_range(0, 6)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable binary down-counter with start/pause control, internal tick prescaler and a one-cycle expiry pulse. It is the decrementing counterpart to the free-running up-counter used for display refresh. It sits between the user-control logic (debounced buttons/switches) and the display path, presenting the remaining count for BCD/7-segment decoding and flagging expiry to the controller.

## Interface
Parameters:
- WIDTH, 8, bit width of the count and load value (≥2)
- PRESCALE, 4, clock cycles per decrement tick (≥1; 1 = decrement every running cycle)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- load  in  1  load load_value into count, return to IDLE
- load_value  in  WIDTH  value captured on load
- start  in  1  level, sampled each cycle; begin/resume counting
- pause  in  1  level, sampled each cycle; suspend counting
- count  out  WIDTH  remaining count, registered
- running  out  1  high while in RUN
- expired  out  1  high while in EXPIRED
- done  out  1  single-cycle pulse on entry to EXPIRED

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED.
- Reset: state IDLE, count 0, running 0, expired 0, done 0, prescaler 0.
- Priority each cycle: reset > load > pause > start > tick.
- load (any non-reset state): count ← load_value, state → IDLE, prescaler cleared, done 0.
- IDLE: start && !pause && count≠0 → RUN, prescaler cleared. start && !pause && count==0 → EXPIRED with done pulse. pause alone: no effect.
- RUN: prescaler increments each cycle, wraps at PRESCALE−1; tick asserted in the cycle the prescaler equals PRESCALE−1. On tick: count ← count−1. If count==1 at tick: count ← 0, state → EXPIRED, done ← 1 in the same edge. pause → PAUSED, no decrement that cycle even if tick, prescaler holds.
- PAUSED: count and prescaler hold. start && !pause → RUN, prescaler resumes from held value. start && pause → stay PAUSED.
- EXPIRED: count holds 0, expired 1; start and pause ignored; leave only via load or reset.
- count never wraps below 0; no decrement in IDLE, PAUSED, EXPIRED.
- running, expired are registered decodes of state; done is high exactly one cycle.

## Timing
- All outputs registered; change only on rising clk edge.
- start sampled at edge k → running high after edge k.
- First decrement at edge k+PRESCALE; subsequent decrements every PRESCALE edges.
- Loaded value N (N≥1), uninterrupted: count==0, expired=1, done=1 after edge k+N·PRESCALE; done low after the next edge.
- Pause for M cycles adds exactly M cycles to expiry time (prescaler phase preserved).
- load takes effect at the sampling edge; a concurrent tick is discarded.
- Reset mid-RUN: all outputs to reset values at that edge, no done pulse.

## Structure
- Package countdown_pkg: typedef enum logic [1:0] state_t {IDLE, RUN, PAUSED, EXPIRED}.
- Sub-module tick_gen (parameter PRESCALE; ports clk, reset, en, clr, tick): prescaler counter of width $clog2(PRESCALE) (min 1); tick combinational = en && cnt==PRESCALE−1; PRESCALE==1 gives tick = en.
- Top: state register + next-state logic, count register, done register.

## Test plan
- Reset: assert reset 2 cycles mid-RUN with count=5 → count 0, state IDLE, running/expired/done 0, no done pulse.
- Basic countdown, PRESCALE=4: load 3, start at edge k → count 3→2→1→0 at edges k+4, k+8, k+12; done high one cycle after k+12; expired stays 1.
- Pause/resume, PRESCALE=1: load 10, start, pause after 4 decrements for 7 cycles → count holds 6 throughout; resume → expiry 7 cycles later than the uninterrupted run.
- Zero/boundary: load 0, start → EXPIRED next edge with one done pulse, count 0; start again in EXPIRED → no change, no second pulse.
- Simultaneous events: start && pause in IDLE → stays IDLE; load 9 during RUN in the same cycle as a tick → count 9, IDLE, no decrement.
- Max value, WIDTH=8, PRESCALE=1: load 255, start → done exactly 255 cycles after RUN entry, count never wraps to 255.
